// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard stall, bubbles, flush and hold
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic [4:0]        D_rd,
  input  logic              D_usesRt,
  input  logic [DATA_W-1:0] D_rsVal,
  input  logic [DATA_W-1:0] D_rtVal,
  input  logic [DATA_W-1:0] D_imm,
  input  logic              D_regWrite,
  input  logic              D_memRead,
  input  logic              D_memWrite,
  input  logic              D_memToReg,
  input  logic              D_aluSrc,
  input  logic [3:0]        D_aluOp,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              X_valid,
  output logic [4:0]        X_rs,
  output logic [4:0]        X_rt,
  output logic [4:0]        X_rd,
  output logic [DATA_W-1:0] X_rsVal,
  output logic [DATA_W-1:0] X_rtVal,
  output logic [DATA_W-1:0] X_imm,
  output logic              X_regWrite,
  output logic              X_memRead,
  output logic              X_memWrite,
  output logic              X_memToReg,
  output logic              X_aluSrc,
  output logic [3:0]        X_aluOp,
  output logic [CNT_W-1:0]  bubbleCnt,
  output logic [CNT_W-1:0]  flushCnt
);
  logic load_use, kill;
  // hazard detection: a load in execute feeding a source of the decode instruction
  always_comb begin
    load_use = X_valid & X_memRead & (X_rd != 5'd0) &
               ((X_rd == D_rs) | (D_usesRt & (X_rd == D_rt)));
    stall    = (load_use | ex_hold) & ~flush;
    kill     = flush | (~ex_hold & load_use);
  end
  // execute slot: flush bubble > hold > load-use bubble > normal load; counters saturate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      X_valid    <= 1'b0;
      X_rs       <= '0;
      X_rt       <= '0;
      X_rd       <= '0;
      X_rsVal    <= '0;
      X_rtVal    <= '0;
      X_imm      <= '0;
      X_regWrite <= 1'b0;
      X_memRead  <= 1'b0;
      X_memWrite <= 1'b0;
      X_memToReg <= 1'b0;
      X_aluSrc   <= 1'b0;
      X_aluOp    <= '0;
      bubbleCnt  <= '0;
      flushCnt   <= '0;
    end else if (kill) begin
      X_valid    <= 1'b0;
      X_rs       <= '0;
      X_rt       <= '0;
      X_rd       <= '0;
      X_rsVal    <= '0;
      X_rtVal    <= '0;
      X_imm      <= '0;
      X_regWrite <= 1'b0;
      X_memRead  <= 1'b0;
      X_memWrite <= 1'b0;
      X_memToReg <= 1'b0;
      X_aluSrc   <= 1'b0;
      X_aluOp    <= '0;
      if (flush) flushCnt <= flushCnt + CNT_W'(~&flushCnt);
      else bubbleCnt <= bubbleCnt + CNT_W'(~&bubbleCnt);
    end else if (!ex_hold) begin
      X_valid    <= 1'b1;
      X_rs       <= D_rs;
      X_rt       <= D_rt;
      X_rd       <= D_rd;
      X_rsVal    <= D_rsVal;
      X_rtVal    <= D_rtVal;
      X_imm      <= D_imm;
      X_regWrite <= D_regWrite;
      X_memRead  <= D_memRead;
      X_memWrite <= D_memWrite;
      X_memToReg <= D_memToReg;
      X_aluSrc   <= D_aluSrc;
      X_aluOp    <= D_aluOp;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX register, hazard stall, flush, hold and counters
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  typedef struct packed {
    logic v;
    logic [4:0] rs, rt, rd;
    logic [DATA_W-1:0] rsv, rtv, imm;
    logic rw, mr, mw, m2r, as;
    logic [3:0] op;
  } xs_t;
  logic clk = 1'b0, rst = 1'b0, uses_rt = 1'b0, flush = 1'b0, ex_hold = 1'b0;
  xs_t d = '0;
  logic stall, X_valid, X_regWrite, X_memRead, X_memWrite, X_memToReg, X_aluSrc;
  logic [4:0] X_rs, X_rt, X_rd;
  logic [DATA_W-1:0] X_rsVal, X_rtVal, X_imm;
  logic [3:0] X_aluOp;
  logic [CNT_W-1:0] bubbleCnt, flushCnt;
  logic [CNT_W-1:0] exp_bub = '0, exp_fl = '0;
  xs_t exp_q[$];
  xs_t e, got, held;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .D_rs(d.rs), .D_rt(d.rt), .D_rd(d.rd), .D_usesRt(uses_rt),
    .D_rsVal(d.rsv), .D_rtVal(d.rtv), .D_imm(d.imm),
    .D_regWrite(d.rw), .D_memRead(d.mr), .D_memWrite(d.mw), .D_memToReg(d.m2r),
    .D_aluSrc(d.as), .D_aluOp(d.op), .flush(flush), .ex_hold(ex_hold), .stall(stall),
    .X_valid(X_valid), .X_rs(X_rs), .X_rt(X_rt), .X_rd(X_rd),
    .X_rsVal(X_rsVal), .X_rtVal(X_rtVal), .X_imm(X_imm),
    .X_regWrite(X_regWrite), .X_memRead(X_memRead), .X_memWrite(X_memWrite),
    .X_memToReg(X_memToReg), .X_aluSrc(X_aluSrc), .X_aluOp(X_aluOp),
    .bubbleCnt(bubbleCnt), .flushCnt(flushCnt)
  );
  function automatic xs_t x_now();
    return {X_valid, X_rs, X_rt, X_rd, X_rsVal, X_rtVal, X_imm,
            X_regWrite, X_memRead, X_memWrite, X_memToReg, X_aluSrc, X_aluOp};
  endfunction
  function automatic xs_t rand_d();
    xs_t r;
    r.v = 1'b1;
    r.rs = 5'($urandom);
    r.rt = 5'($urandom);
    r.rd = 5'($urandom_range(1, 31));
    r.rsv = $urandom;
    r.rtv = $urandom;
    r.imm = $urandom;
    r.rw = 1'b1;
    r.mr = 1'b0;
    r.mw = 1'($urandom);
    r.m2r = 1'($urandom);
    r.as = 1'($urandom);
    r.op = 4'($urandom_range(1, 15));
    return r;
  endfunction
  function automatic xs_t mk_lw(input logic [4:0] rd);
    xs_t r = rand_d();
    r.rd = rd;
    r.mr = 1'b1;
    r.m2r = 1'b1;
    r.mw = 1'b0;
    return r;
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction
  task automatic tick(input xs_t ex);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    d = rand_d();
    d.mr = 1'b1;
    uses_rt = 1'b1;
    #1;
    if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    ex_hold = 1'b1;
    #1;
    if (stall !== 1'b1) begin $display("FAIL reset_stall_hold: got %b expected 1", stall); n_bad++; end
    n_cmp++;
    ex_hold = 1'b0;
    repeat (3) tick('0);
    repeat (3) begin
      got = x_now();
      e = exp_q.pop_front();
      if (got !== e) begin $display("FAIL reset_x: got %h expected %h", got, e); n_bad++; end
      n_cmp++;
    end
    if (bubbleCnt !== '0 || flushCnt !== '0) begin
      $display("FAIL reset_cnt: got %h/%h expected 0/0", bubbleCnt, flushCnt); n_bad++;
    end
    n_cmp++;
    rst = 1'b1;
    d = rand_d();
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL reset_release: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
  endtask
  task automatic test_load_use_rs();
    d = mk_lw(5'd5);
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lu_load: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
    d = rand_d();
    d.rs = 5'd5;
    d.rt = 5'd6;
    d.rd = 5'd8;
    #1;
    if (stall !== 1'b1) begin $display("FAIL lu_stall: got %b expected 1", stall); n_bad++; end
    n_cmp++;
    exp_bub = sat_inc(exp_bub);
    tick('0);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e || bubbleCnt !== exp_bub) begin
      $display("FAIL lu_bubble: got %h cnt %h expected %h cnt %h", got, bubbleCnt, e, exp_bub); n_bad++;
    end
    n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL lu_release: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL lu_advance: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
  endtask
  task automatic test_rt_gating();
    d = mk_lw(5'd7);
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL rt_load: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
    d = mk_lw(5'd0);
    d.rs = 5'd3;
    d.rt = 5'd7;
    uses_rt = 1'b0;
    #1;
    if (stall !== 1'b0) begin $display("FAIL rt_unused: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    uses_rt = 1'b1;
    #1;
    if (stall !== 1'b1) begin $display("FAIL rt_used: got %b expected 1", stall); n_bad++; end
    n_cmp++;
    uses_rt = 1'b0;
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e || bubbleCnt !== exp_bub) begin
      $display("FAIL rt_independent: got %h cnt %h expected %h cnt %h", got, bubbleCnt, e, exp_bub); n_bad++;
    end
    n_cmp++;
    d = rand_d();
    d.rs = 5'd0;
    d.rt = 5'd0;
    uses_rt = 1'b1;
    #1;
    if (stall !== 1'b0) begin $display("FAIL rt_rd_zero: got %b expected 0", stall); n_bad++; end
    n_cmp++;
  endtask
  task automatic test_flush();
    d = mk_lw(5'd9);
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL fl_load: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
    d = rand_d();
    d.rs = 5'd9;
    flush = 1'b1;
    #1;
    if (stall !== 1'b0) begin $display("FAIL fl_stall: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    exp_fl = sat_inc(exp_fl);
    tick('0);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e || flushCnt !== exp_fl || bubbleCnt !== exp_bub) begin
      $display("FAIL fl_bubble: got %h cnt %h/%h expected %h cnt %h/%h",
               got, bubbleCnt, flushCnt, e, exp_bub, exp_fl); n_bad++;
    end
    n_cmp++;
    flush = 1'b0;
    d = rand_d();
    tick(d);
    void'(exp_q.pop_front());
    ex_hold = 1'b1;
    flush = 1'b1;
    #1;
    if (stall !== 1'b0) begin $display("FAIL fl_hold_stall: got %b expected 0", stall); n_bad++; end
    n_cmp++;
    exp_fl = sat_inc(exp_fl);
    tick('0);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e || flushCnt !== exp_fl) begin
      $display("FAIL fl_hold_kill: got %h cnt %h expected %h cnt %h", got, flushCnt, e, exp_fl); n_bad++;
    end
    n_cmp++;
    flush = 1'b0;
    ex_hold = 1'b0;
  endtask
  task automatic test_hold();
    held = rand_d();
    d = held;
    tick(d);
    void'(exp_q.pop_front());
    ex_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = rand_d();
      #1;
      if (stall !== 1'b1) begin $display("FAIL hold_stall: got %b expected 1", stall); n_bad++; end
      n_cmp++;
      tick(held);
      got = x_now();
      e = exp_q.pop_front();
      if (got !== e || bubbleCnt !== exp_bub || flushCnt !== exp_fl) begin
        $display("FAIL hold_x: got %h cnt %h/%h expected %h cnt %h/%h",
                 got, bubbleCnt, flushCnt, e, exp_bub, exp_fl); n_bad++;
      end
      n_cmp++;
    end
    ex_hold = 1'b0;
    d = mk_lw(5'd4);
    held = d;
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL hold_release: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
    d = rand_d();
    d.rs = 5'd4;
    ex_hold = 1'b1;
    #1;
    if (stall !== 1'b1) begin $display("FAIL hold_lu_stall: got %b expected 1", stall); n_bad++; end
    n_cmp++;
    tick(held);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e || bubbleCnt !== exp_bub) begin
      $display("FAIL hold_lu_x: got %h cnt %h expected %h cnt %h", got, bubbleCnt, e, exp_bub); n_bad++;
    end
    n_cmp++;
    ex_hold = 1'b0;
    exp_bub = sat_inc(exp_bub);
    tick('0);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e || bubbleCnt !== exp_bub) begin
      $display("FAIL hold_lu_bubble: got %h cnt %h expected %h cnt %h", got, bubbleCnt, e, exp_bub); n_bad++;
    end
    n_cmp++;
    tick(d);
    got = x_now();
    e = exp_q.pop_front();
    if (got !== e) begin $display("FAIL hold_lu_advance: got %h expected %h", got, e); n_bad++; end
    n_cmp++;
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      d = rand_d();
      uses_rt = 1'($urandom);
      tick(d);
      got = x_now();
      e = exp_q.pop_front();
      if (got !== e || stall !== 1'b0) begin
        $display("FAIL b2b_%0d: got %h stall %b expected %h stall 0", i, got, stall, e); n_bad++;
      end
      n_cmp++;
    end
  endtask
  task automatic test_saturation();
    for (int i = 0; i < int'(CMAX) + 4; i++) begin
      d = mk_lw(5'd5);
      tick(d);
      void'(exp_q.pop_front());
      d = rand_d();
      d.rs = 5'd5;
      exp_bub = sat_inc(exp_bub);
      tick('0);
      void'(exp_q.pop_front());
      if (bubbleCnt !== exp_bub) begin
        $display("FAIL sat_%0d: got %h expected %h", i, bubbleCnt, exp_bub); n_bad++;
      end
      n_cmp++;
    end
    if (bubbleCnt !== CMAX) begin $display("FAIL sat_final: got %h expected %h", bubbleCnt, CMAX); n_bad++; end
    n_cmp++;
    d = rand_d();
    tick(d);
    void'(exp_q.pop_front());
    #2;
    rst = 1'b0;
    #1;
    got = x_now();
    if (got !== '0 || bubbleCnt !== '0 || flushCnt !== '0) begin
      $display("FAIL async_reset: got %h cnt %h/%h expected 0", got, bubbleCnt, flushCnt); n_bad++;
    end
    n_cmp++;
    rst = 1'b1;
  endtask
  initial begin
    test_reset();
    test_load_use_rs();
    test_rt_gating();
    test_flush();
    test_hold();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded operands, register specifiers and control bits from decode and presents them to execute. Its registered X_rd/X_regWrite outputs drive the forwarding unit, which compares them against the decode specifiers. It also generates the upstream stall that freezes PC and IF/ID, inserts bubbles, and honours branch flushes and downstream holds.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- CNT_W, 16, width of the saturating event counters

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- D_rs, D_rt, D_rd  input  5 each  decode register specifiers (D_rd is the already-selected destination)
- D_usesRt  input  1  instruction reads rt as a source (R-type, store, branch)
- D_rsVal, D_rtVal, D_imm  input  DATA_W each  register-file read data, sign-extended immediate
- D_regWrite, D_memRead, D_memWrite, D_memToReg, D_aluSrc  input  1 each  decode control
- D_aluOp  input  4  ALU operation
- flush  input  1  branch/jump redirect; kill the instruction entering execute
- ex_hold  input  1  downstream (memory) wait; freeze execute
- stall  output  1  freeze PC and IF/ID this cycle (combinational)
- X_valid  output  1  execute slot holds a real instruction
- X_rs, X_rt, X_rd  output  5 each  registered specifiers
- X_rsVal, X_rtVal, X_imm  output  DATA_W each  registered data
- X_regWrite, X_memRead, X_memWrite, X_memToReg, X_aluSrc  output  1 each  registered control
- X_aluOp  output  4  registered ALU op
- bubbleCnt, flushCnt  output  CNT_W each  saturating event counters

## Operation
- load_use = X_valid & X_memRead & (X_rd != 0) & ((X_rd == D_rs) | (D_usesRt & (X_rd == D_rt)))
- stall = (load_use | ex_hold) & ~flush.
- Per-edge update priority, highest first:
  1. flush: load bubble; flushCnt += 1 (saturating).
  2. ex_hold: all X_* registers hold their current values; counters unchanged.
  3. load_use: load bubble; bubbleCnt += 1 (saturating).
  4. otherwise: load all D_* into X_*; X_valid = 1.
- Bubble: X_valid = 0; X_regWrite, X_memRead, X_memWrite, X_memToReg, X_aluSrc = 0; X_aluOp = 0; X_rd = 0. Specifiers and data fields are don't-care but are zeroed.
- A bubble must never cause a write or memory access downstream. X_rd = 0 ensures the forwarding unit never matches a bubble.
- Counters stop at all-ones; they never wrap.

## Timing
- Reset (rst low, asynchronous): every X_* output, X_valid, bubbleCnt and flushCnt go to 0 immediately. stall then evaluates to ex_hold & ~flush.
- Register latency: D_* at edge N appear on X_* after edge N.
- stall is combinational from D_*, X_*, ex_hold and flush in the same cycle. It has no register stage.
- Load-use stall lasts exactly one cycle. After the bubble, X_memRead = 0, so load_use drops. The held decode instruction then advances on the next edge.
- A load followed by an independent instruction (no rs/rt match, or rt match with D_usesRt = 0) causes no stall.
- A load whose X_rd = 0 never stalls.
- flush together with load_use: the flush bubble wins, stall = 0, and only flushCnt increments.
- flush together with ex_hold: the flush wins and the X slot is killed.
- ex_hold together with load_use: X holds, stall = 1, and bubbleCnt does not increment until the hold releases.
- Reset deasserting mid-stream: the first edge after release loads D_* normally, unless flush, ex_hold or load_use is active.

## Test plan
- Reset: drive D_* nonzero and hold rst = 0 for 3 cycles. Then X_valid = 0, X_regWrite = 0, X_rd = 0, both counters = 0. After release, the first edge gives X_rsVal = D_rsVal and X_valid = 1.
- Load-use on rs: load `lw $5` enters X (X_memRead = 1, X_rd = 5); decode presents `add` with D_rs = 5. Then stall = 1 that cycle, the next edge gives X_valid = 0 and X_regWrite = 0, bubbleCnt = 1, and the following edge loads the `add` with stall = 0.
- rt gating: X holds a load with X_rd = 7; D_rt = 7, D_rs = 3.
  - D_usesRt = 0: stall = 0.
  - D_usesRt = 1: stall = 1.
  - Same case with X_rd = 0: stall = 0.
- Flush priority: load-use condition active and flush = 1. Then stall = 0, the next X_valid = 0, flushCnt = 1, bubbleCnt unchanged.
- ex_hold: hold for 4 cycles while D_* changes. X_* stays constant, stall = 1 throughout, no counter change. On release, X loads the current D_*.
- Saturation: preload by forcing 2^CNT_W − 1 load-use events. Then bubbleCnt = 0xFFFF for CNT_W = 16 and stays at 0xFFFF on further events.
